muldiv_unit: RTL

Iterative multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the register file in the execute stage. It consumes the two GPR read ports as operands. It provides HI/LO to the writeback mux for MFHI/MFLO, and to GPR write_data through that mux. While an operation is in flight it raises `busy`, and the pipeline stalls any MFHI/MFLO/MTHI/MTLO or new mul/div until `busy` drops.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle, 32 steps, then a sign-fixup cycle that commits HI/LO.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   // state | meaning
   // IDLE  | HI/LO stable, accepts start or MTHI/MTLO
   // CALC  | 32 shift-add / restoring-divide iterations
   // FIX   | apply result signs and commit HI/LO
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t      r_state, w_next;
   logic [4:0]  r_cnt;
   logic        r_is_div;
   logic        r_sign_q;
   logic        r_sign_r;
   logic [31:0] r_acc_hi;
   logic [31:0] r_acc_lo;
   logic [31:0] r_b;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;

   logic        w_signed;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_mul_sum;
   logic [32:0] w_div_shift;
   logic [32:0] w_div_diff;
   logic [63:0] w_prod;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   assign w_signed = ~op[0];
   assign w_a_mag  = (w_signed && rs_data[31]) ? -rs_data : rs_data;
   assign w_b_mag  = (w_signed && rt_data[31]) ? -rt_data : rt_data;

   // Multiply: acc_lo holds the shrinking multiplier, acc_hi the partial product.
   assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);
   // Divide: acc_lo holds the dividend shifting into quotient, acc_hi the remainder.
   assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
   assign w_div_diff  = w_div_shift - {1'b0, r_b};

   assign w_prod      = {r_acc_hi, r_acc_lo};
   assign w_prod_fix  = r_sign_q ? -w_prod : w_prod;
   // With a zero divisor every trial subtract succeeds, so the remainder ends up
   // as |rs|; negating by the rs sign restores the original rs for HI.
   assign w_quo_fix   = (r_b == 32'd0) ? 32'hFFFF_FFFF : (r_sign_q ? -r_acc_lo : r_acc_lo);
   assign w_rem_fix   = r_sign_r ? -r_acc_hi : r_acc_hi;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CALC;
         S_CALC:  if (r_cnt == 5'd0) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= 5'd0;
         r_is_div <= 1'b0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_acc_hi <= 32'd0;
         r_acc_lo <= 32'd0;
         r_b      <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt    <= 5'd31;
                  r_is_div <= op[1];
                  r_sign_q <= w_signed & (rs_data[31] ^ rt_data[31]);
                  r_sign_r <= w_signed & rs_data[31];
                  r_acc_hi <= 32'd0;
                  r_acc_lo <= w_a_mag;
                  r_b      <= w_b_mag;
                  if (!op[1]) begin
                     r_acc_lo <= w_b_mag;
                     r_b      <= w_a_mag;
                  end
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt - 5'd1;
               if (r_is_div) begin
                  if (!w_div_diff[32]) begin
                     r_acc_hi <= w_div_diff[31:0];
                     r_acc_lo <= {r_acc_lo[30:0], 1'b1};
                  end else begin
                     r_acc_hi <= w_div_shift[31:0];
                     r_acc_lo <= {r_acc_lo[30:0], 1'b0};
                  end
               end else begin
                  r_acc_hi <= w_mul_sum[32:1];
                  r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
               end
            end
            S_FIX: begin
               r_done <= 1'b1;
               if (r_is_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else begin
                  r_hi <= w_prod_fix[63:32];
                  r_lo <= w_prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = (r_state != S_IDLE);
   assign done = r_done;

endmodule
